// File: rtl/config_reg_bank.sv
// Bank of NUM_REGS configuration registers on the serial config message path.
// Out-of-range messages are forwarded unchanged. Optional lock register: CFG_REG_BANK_LOCK_EN.
module config_reg_bank #(
  parameter int ADDR_SIZE    = 4,
  parameter int PAYLOAD_SIZE = 8,
  parameter int NUM_REGS     = 4,
  parameter int BASE_ADDR    = 0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ADDR_SIZE+PAYLOAD_SIZE:0]       recv_msg,
  input  logic                                  recv_val,
  output logic                                  recv_rdy,
  output logic [ADDR_SIZE+PAYLOAD_SIZE:0]       send_msg,
  output logic                                  send_val,
  input  logic                                  send_rdy,
  output logic [NUM_REGS*PAYLOAD_SIZE-1:0]      cfg_out,
  output logic [NUM_REGS-1:0]                   cfg_update
);

  localparam int MSG_W = ADDR_SIZE + PAYLOAD_SIZE + 1;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_SIZE:0] BASE_EXT = (ADDR_SIZE+1)'(BASE_ADDR);
  localparam logic [ADDR_SIZE:0] END_EXT  = (ADDR_SIZE+1)'(BASE_ADDR + NUM_REGS);

  logic [NUM_REGS-1:0][PAYLOAD_SIZE-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                   cfg_update_q, cfg_update_d;
  logic                                  send_val_q, send_val_d;
  logic [MSG_W-1:0]                      send_msg_q, send_msg_d;

  logic [ADDR_SIZE-1:0]    addr;
  logic [ADDR_SIZE:0]      addr_ext;
  logic                    wr;
  logic [PAYLOAD_SIZE-1:0] payload;
  logic [IDX_W-1:0]        idx;
  logic                    in_range;
  logic                    accept;

  assign addr     = recv_msg[MSG_W-1 -: ADDR_SIZE];
  assign wr       = recv_msg[PAYLOAD_SIZE];
  assign payload  = recv_msg[PAYLOAD_SIZE-1:0];
  // Extra address bit keeps the subtraction and upper-bound compare from wrapping.
  assign addr_ext = {1'b0, addr};
  assign idx      = IDX_W'(addr_ext - BASE_EXT);
  assign in_range = (addr_ext >= BASE_EXT) && (addr_ext < END_EXT);

  // Ready depends only on the output register, never on recv_val.
  assign recv_rdy = !send_val_q || send_rdy;
  assign accept   = recv_val && recv_rdy;

`ifdef CFG_REG_BANK_LOCK_EN
  logic lock_q, lock_d;
  logic is_lock;
  assign is_lock = (addr_ext == END_EXT);
`endif

  always_comb begin
    regs_d       = regs_q;
    cfg_update_d = '0;
    send_val_d   = send_val_q;
    send_msg_d   = send_msg_q;
`ifdef CFG_REG_BANK_LOCK_EN
    lock_d       = lock_q;
`endif
    if (send_val_q && send_rdy) send_val_d = 1'b0;
    if (accept) begin
      if (in_range) begin
        if (wr) begin
`ifdef CFG_REG_BANK_LOCK_EN
          if (!lock_q) begin
            regs_d[idx]       = payload;
            cfg_update_d[idx] = 1'b1;
          end
`else
          regs_d[idx]       = payload;
          cfg_update_d[idx] = 1'b1;
`endif
        end else begin
          send_val_d = 1'b1;
          send_msg_d = {addr, 1'b0, regs_q[idx]};
        end
`ifdef CFG_REG_BANK_LOCK_EN
      end else if (is_lock) begin
        if (wr) begin
          lock_d = lock_q | payload[0];
        end else begin
          send_val_d = 1'b1;
          send_msg_d = {addr, 1'b0, {(PAYLOAD_SIZE-1){1'b0}}, lock_q};
        end
`endif
      end else begin
        send_val_d = 1'b1;
        send_msg_d = recv_msg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q       <= '0;
      cfg_update_q <= '0;
      send_val_q   <= 1'b0;
      send_msg_q   <= '0;
`ifdef CFG_REG_BANK_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      regs_q       <= regs_d;
      cfg_update_q <= cfg_update_d;
      send_val_q   <= send_val_d;
      send_msg_q   <= send_msg_d;
`ifdef CFG_REG_BANK_LOCK_EN
      lock_q       <= lock_d;
`endif
    end
  end

  assign cfg_out    = regs_q;
  assign cfg_update = cfg_update_q;
  assign send_val   = send_val_q;
  assign send_msg   = send_msg_q;

endmodule

// File: tb/tb_config_reg_bank.sv
// Directed bench for config_reg_bank (ADDR_SIZE=4, PAYLOAD_SIZE=8, NUM_REGS=4, BASE_ADDR=2).
module tb_config_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] recv_msg;
  logic        recv_val;
  logic        recv_rdy;
  logic [12:0] send_msg;
  logic        send_val;
  logic        send_rdy;
  logic [31:0] cfg_out;
  logic [3:0]  cfg_update;

  int checks   = 0;
  int failures = 0;

  config_reg_bank #(.ADDR_SIZE(4), .PAYLOAD_SIZE(8), .NUM_REGS(4), .BASE_ADDR(2)) dut (
    .clk(clk), .reset(reset),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .cfg_out(cfg_out), .cfg_update(cfg_update)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    recv_val = 1'b1;
    recv_msg = 13'b0011_1_11111111;
    send_rdy = 1'b1;
    step();
    step();
    check("rst_cfg_out", 64'(cfg_out), 64'h0);
    check("rst_cfg_update", 64'(cfg_update), 64'h0);
    check("rst_send_val", 64'(send_val), 64'h0);
    check("rst_send_msg", 64'(send_msg), 64'h0);
    reset    = 1'b0;
    recv_val = 1'b0;
    #1;
    check("rst_recv_rdy", 64'(recv_rdy), 64'h1);

    // write addr 3 = A5
    recv_val = 1'b1;
    recv_msg = 13'b0011_1_10100101;
    step();
    check("wr3_cfg_byte", 64'(cfg_out[15:8]), 64'hA5);
    check("wr3_cfg_out", 64'(cfg_out), 64'h0000A500);
    check("wr3_update", 64'(cfg_update), 64'b0010);
    check("wr3_send_val", 64'(send_val), 64'h0);

    // read addr 3 right after the write
    recv_msg = 13'b0011_0_00000000;
    step();
    check("rd3_update_clear", 64'(cfg_update), 64'h0);
    check("rd3_send_val", 64'(send_val), 64'h1);
    check("rd3_send_msg", 64'(send_msg), 64'(13'b0011_0_10100101));

    // out-of-range write addr 9 forwarded, replacing the drained response
    recv_msg = 13'b1001_1_01010101;
    step();
    check("fwd9_send_val", 64'(send_val), 64'h1);
    check("fwd9_send_msg", 64'(send_msg), 64'(13'b1001_1_01010101));
    check("fwd9_cfg_out", 64'(cfg_out), 64'h0000A500);
    check("fwd9_update", 64'(cfg_update), 64'h0);

    // addr 1 sits just below the bank
    recv_msg = 13'b0001_1_11110000;
    step();
    check("fwd1_send_msg", 64'(send_msg), 64'(13'b0001_1_11110000));
    check("fwd1_cfg_out", 64'(cfg_out), 64'h0000A500);

    // top register, addr 5
    recv_msg = 13'b0101_1_00111100;
    step();
    check("wr5_update", 64'(cfg_update), 64'b1000);
    check("wr5_cfg_out", 64'(cfg_out), 64'h3C00A500);
    check("wr5_send_val", 64'(send_val), 64'h0);

    // unchanged value still pulses
    recv_msg = 13'b0011_1_10100101;
    step();
    check("rewr3_update", 64'(cfg_update), 64'b0010);
    check("rewr3_cfg_out", 64'(cfg_out), 64'h3C00A500);

    // backpressure: pending read of addr 3, second read of addr 2 presented
    recv_msg = 13'b0011_0_00000000;
    step();
    check("bp_first_msg", 64'(send_msg), 64'(13'b0011_0_10100101));
    send_rdy = 1'b0;
    recv_msg = 13'b0010_0_00000000;
    #1;
    check("bp_recv_rdy_low", 64'(recv_rdy), 64'h0);
    step();
    check("bp_hold1_val", 64'(send_val), 64'h1);
    check("bp_hold1_msg", 64'(send_msg), 64'(13'b0011_0_10100101));
    step();
    check("bp_hold2_msg", 64'(send_msg), 64'(13'b0011_0_10100101));
    send_rdy = 1'b1;
    #1;
    check("bp_recv_rdy_high", 64'(recv_rdy), 64'h1);
    step();
    check("bp_second_val", 64'(send_val), 64'h1);
    check("bp_second_msg", 64'(send_msg), 64'(13'b0010_0_00000000));
    recv_val = 1'b0;
    step();
    check("drain_send_val", 64'(send_val), 64'h0);

`ifdef CFG_REG_BANK_LOCK_EN
    recv_val = 1'b1;
    recv_msg = 13'b0110_1_00000001;
    step();
    check("lock_wr_send_val", 64'(send_val), 64'h0);
    check("lock_wr_update", 64'(cfg_update), 64'h0);
    recv_msg = 13'b0010_1_11111111;
    step();
    check("locked_cfg_out", 64'(cfg_out), 64'h3C00A500);
    check("locked_update", 64'(cfg_update), 64'h0);
    check("locked_send_val", 64'(send_val), 64'h0);
    recv_msg = 13'b0110_1_00000000;
    step();
    recv_msg = 13'b0110_0_00000000;
    step();
    check("lock_rd_msg", 64'(send_msg), 64'(13'b0110_0_00000001));
    recv_val = 1'b0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    recv_val = 1'b1;
    recv_msg = 13'b0010_1_11111111;
    step();
    check("unlock_cfg_byte", 64'(cfg_out[7:0]), 64'hFF);
    check("unlock_update", 64'(cfg_update), 64'b0001);
`else
    recv_val = 1'b1;
    recv_msg = 13'b0110_1_00000001;
    step();
    check("fwd6_send_val", 64'(send_val), 64'h1);
    check("fwd6_send_msg", 64'(send_msg), 64'(13'b0110_1_00000001));
    check("fwd6_update", 64'(cfg_update), 64'h0);
`endif

    // mid-operation reset: pending output discarded, write at reset edge ignored
    send_rdy = 1'b0;
    recv_msg = 13'b1111_0_00001111;
    step();
    check("pend_send_val", 64'(send_val), 64'h1);
    reset    = 1'b1;
    recv_msg = 13'b0100_1_01100110;
    step();
    check("midrst_send_val", 64'(send_val), 64'h0);
    check("midrst_cfg_out", 64'(cfg_out), 64'h0);
    reset    = 1'b0;
    recv_val = 1'b0;
    send_rdy = 1'b1;
    step();
    check("midrst_update", 64'(cfg_update), 64'h0);
    check("midrst_send_val2", 64'(send_val), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
